seg7_display_arbiter: RTL and testbench



---
 rtl/seg7_display_arbiter_if.sv | 22 ++
 rtl/seg7_display_arbiter.sv | 162 ++++++++++++++++
 tb/tb_seg7_display_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/seg7_display_arbiter_if.sv
// Request/value bus from the game, status and alert logic, plus the display pins driven by the arbiter.
// The arbiter connects as slave and the requesting side connects as master.
interface seg7_display_arbiter_if;
  logic [2:0]  req;
  logic [15:0] val0;
  logic [15:0] val1;
  logic [15:0] val2;
  logic [2:0]  gnt;
  logic        frame_tick;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  modport master (
    output req, val0, val1, val2,
    input  gnt, frame_tick, DIGIT, DISPLAY
  );

  modport slave (
    input  req, val0, val1, val2,
    output gnt, frame_tick, DIGIT, DISPLAY
  );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Priority arbiter for the shared 4-digit 7-segment display.
// The owner's value is latched once per frame, then scanned out as active-low anodes and segments.
module seg7_display_arbiter #(
  parameter int SCAN_DIV = 16384,
  parameter int MIN_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_display_arbiter_if.slave bus
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  logic [DW-1:0] div_cnt_reg;
  logic [1:0]    idx_reg;
  logic [1:0]    idx_next;
  logic [15:0]   buf_reg;
  logic [15:0]   buf_next;
  logic [15:0]   load_val;
  logic [3:0]    digit_reg;
  logic [6:0]    display_reg;
  logic          frame_tick_reg;
  state_t        state_reg, state_next;
  logic [1:0]    owner_reg, owner_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          advance;
  logic          boundary;
  logic [2:0]    own_mask;
  logic [2:0]    higher_mask;
  logic [2:0]    rem_req;
  logic [15:0]   val_arr [3];

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      4'd10:   seg_decode = 7'b0001000;
      4'd11:   seg_decode = 7'b0000011;
      4'd12:   seg_decode = 7'b0111111;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Fixed priority: lowest set bit wins.
  function automatic logic [1:0] pick(input logic [2:0] m);
    if (m[0])      pick = 2'd0;
    else if (m[1]) pick = 2'd1;
    else           pick = 2'd2;
  endfunction

  assign val_arr[0] = bus.val0;
  assign val_arr[1] = bus.val1;
  assign val_arr[2] = bus.val2;

  assign advance  = (div_cnt_reg == DW'(SCAN_DIV - 1));
  assign boundary = advance && (idx_reg == 2'd3);
  assign idx_next = idx_reg + 2'd1;
  assign buf_next = boundary ? load_val : buf_reg;

  // Digit 0 at a boundary must decode the freshly loaded value, hence buf_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg    <= '0;
      idx_reg        <= 2'd0;
      digit_reg      <= 4'b1110;
      display_reg    <= 7'b1111111;
      frame_tick_reg <= 1'b0;
      buf_reg        <= 16'hFFFF;
    end else begin
      frame_tick_reg <= boundary;
      buf_reg        <= buf_next;
      if (advance) begin
        div_cnt_reg <= '0;
        idx_reg     <= idx_next;
        digit_reg   <= ~(4'b0001 << idx_next);
        display_reg <= seg_decode(buf_next[{idx_next, 2'b00} +: 4]);
      end else begin
        div_cnt_reg <= div_cnt_reg + DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 2'd0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      hold_reg  <= hold_next;
    end
  end

  assign own_mask    = 3'b001 << owner_reg;
  assign higher_mask = own_mask - 3'd1;
  assign rem_req     = bus.req & ~own_mask;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    hold_next  = hold_reg;
    if (boundary) begin
      case (state_reg)
        IDLE: begin
          if (|bus.req) begin
            state_next = OWNED;
            owner_next = pick(bus.req);
            hold_next  = HW'(MIN_HOLD);
          end
        end
        OWNED: begin
          if (!(|(bus.req & own_mask))) begin
            if (|rem_req) begin
              owner_next = pick(rem_req);
              hold_next  = HW'(MIN_HOLD);
            end else begin
              state_next = IDLE;
              owner_next = 2'd0;
              hold_next  = '0;
            end
          end else if (hold_reg == '0) begin
            if (|(bus.req & higher_mask)) begin
              owner_next = pick(bus.req & higher_mask);
              hold_next  = HW'(MIN_HOLD);
            end
          end else begin
            hold_next = hold_reg - HW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    load_val = 16'hFFFF;
    if (state_next == OWNED) load_val = val_arr[owner_next];
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_gnt
      assign bus.gnt[gi] = (state_reg == OWNED) && (owner_reg == 2'(gi));
    end
  endgenerate

  assign bus.frame_tick = frame_tick_reg;
  assign bus.DIGIT      = digit_reg;
  assign bus.DISPLAY    = display_reg;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// Directed bench: expected owner/value per frame is queued when stimulus is applied, then popped
// and compared at each frame_tick against gnt and all four scanned digits.
module tb_seg7_display_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_display_arbiter_if bus();

  seg7_display_arbiter #(.SCAN_DIV(4), .MIN_HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0]  gnt;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b0111111;
      default: seg = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] anode(input int d);
    case (d)
      0: anode = 4'b1110;
      1: anode = 4'b1101;
      2: anode = 4'b1011;
      default: anode = 4'b0111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input string tag, input int exp_n);
    int  n    = 0;
    logic seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        n    = i;
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_tick_seen"}, 16'(seen), 16'd1);
    if (exp_n > 0) chk({tag, "_tick_cycle"}, 16'(n), 16'(exp_n));
  endtask

  // Optional mid-frame change (applied right after digit 0 is checked) exercises the once-per-frame latch.
  task automatic check_frame(input string tag, input int exp_n, input logic chg,
                             input logic [15:0] nv1, input logic [2:0] nreq);
    exp_t e;
    wait_tick(tag, exp_n);
    chk({tag, "_sb_nonempty"}, 16'(sb.size() > 0), 16'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_gnt"}, 16'(bus.gnt), 16'(e.gnt));
    chk({tag, "_digit0"}, 16'(bus.DIGIT), 16'(anode(0)));
    chk({tag, "_seg0"}, 16'(bus.DISPLAY), 16'(seg(e.val[3:0])));
    if (chg) begin
      bus.val1 = nv1;
      bus.req  = nreq;
    end
    @(negedge clk);
    chk({tag, "_tick_pulse"}, 16'(bus.frame_tick), 16'd0);
    repeat (3) @(negedge clk);
    for (int d = 1; d < 4; d++) begin
      if (d > 1) repeat (4) @(negedge clk);
      chk($sformatf("%s_digit%0d", tag, d), 16'(bus.DIGIT), 16'(anode(d)));
      chk($sformatf("%s_seg%0d", tag, d), 16'(bus.DISPLAY), 16'(seg(e.val[4*d +: 4])));
    end
    $display("[TB] frame %s gnt=%b val=%h", tag, e.gnt, e.val);
  endtask

  initial begin
    bus.req  = 3'b000;
    bus.val0 = 16'h0567;
    bus.val1 = 16'h1234;
    bus.val2 = 16'h9876;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 16'(bus.gnt), 16'd0);
    chk("rst_digit", 16'(bus.DIGIT), 16'(4'b1110));
    chk("rst_seg", 16'(bus.DISPLAY), 16'(7'b1111111));
    chk("rst_tick", 16'(bus.frame_tick), 16'd0);
    $display("[TB] reset values checked");
    rst = 1'b0;

    sb.push_back('{3'b000, 16'hFFFF});
    check_frame("idle", 16, 1'b1, 16'h1234, 3'b010);
    sb.push_back('{3'b010, 16'h1234});
    check_frame("grant1", 4, 1'b1, 16'hCCAB, 3'b011);
    sb.push_back('{3'b010, 16'hCCAB});
    check_frame("hold_a", 4, 1'b0, 16'h0000, 3'b000);
    sb.push_back('{3'b010, 16'hCCAB});
    check_frame("hold_b", 4, 1'b0, 16'h0000, 3'b000);
    sb.push_back('{3'b001, 16'h0567});
    check_frame("preempt", 4, 1'b1, 16'hCCAB, 3'b110);
    sb.push_back('{3'b010, 16'hCCAB});
    check_frame("drop0", 4, 1'b0, 16'h0000, 3'b000);

    // Mid-frame reset: the pending boundary must not produce a tick.
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 16'(bus.gnt), 16'd0);
    chk("midrst_digit", 16'(bus.DIGIT), 16'(4'b1110));
    chk("midrst_seg", 16'(bus.DISPLAY), 16'(7'b1111111));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_tick", 16'(bus.frame_tick), 16'd0);
    end
    $display("[TB] mid-frame reset checked");
    rst = 1'b0;

    sb.push_back('{3'b010, 16'hCCAB});
    check_frame("after_rst", 16, 1'b1, 16'hCCAB, 3'b100);
    sb.push_back('{3'b100, 16'h9876});
    check_frame("grant2", 4, 1'b1, 16'hCCAB, 3'b000);
    sb.push_back('{3'b000, 16'hFFFF});
    check_frame("release", 4, 1'b0, 16'h0000, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
